// File: rtl/pwm_cmd_sched.sv
// pwm_cmd_sched: frame-synchronous, slew-limited PWM setpoint scheduler with watchdog failsafe
module pwm_cmd_sched #(
  parameter int CNT_WIDTH  = 24,
  parameter int WDOG_WIDTH = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_rstn,
  input  logic                  enable_i,
  input  logic                  frame_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CNT_WIDTH-1:0]  cmd_active_0_i,
  input  logic [CNT_WIDTH-1:0]  cmd_active_1_i,
  input  logic [CNT_WIDTH-1:0]  neutral_0_i,
  input  logic [CNT_WIDTH-1:0]  neutral_1_i,
  input  logic [CNT_WIDTH-1:0]  max_step_i,
  input  logic [WDOG_WIDTH-1:0] wdog_frames_i,
  output logic [CNT_WIDTH-1:0]  active_0_o,
  output logic [CNT_WIDTH-1:0]  active_1_o,
  output logic [1:0]            state_o,
  output logic                  failsafe_o,
  output logic [15:0]           wdog_trip_cnt_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAILSAFE = 2'b10} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d, ready_q, ready_d, accept, expire;
  logic [CNT_WIDTH-1:0] pend0_q, pend0_d, pend1_q, pend1_d;
  logic [CNT_WIDTH-1:0] tgt0_q, tgt0_d, tgt1_q, tgt1_d, act0_q, act0_d, act1_q, act1_d, t0, t1;
  logic [WDOG_WIDTH-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [15:0] trip_q, trip_d;

  function automatic logic [CNT_WIDTH-1:0] slew(input logic [CNT_WIDTH-1:0] a, t, s);
    logic signed [CNT_WIDTH:0] d;
    logic [CNT_WIDTH:0] m;
    d = $signed({1'b0, t}) - $signed({1'b0, a});
    m = d[CNT_WIDTH] ? $unsigned(-d) : $unsigned(d);
    return (s == '0 || m <= {1'b0, s}) ? t : d[CNT_WIDTH] ? a - s : a + s;
  endfunction

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend0_d  = pend0_q;
    pend1_d  = pend1_q;
    tgt0_d   = tgt0_q;
    tgt1_d   = tgt1_q;
    act0_d   = act0_q;
    act1_d   = act1_q;
    wcnt_d   = wcnt_q;
    trip_d   = trip_q;
    accept   = cmd_valid_i & ready_q;
    wcnt_inc = wcnt_q + 1'b1;
    expire   = 1'b0;
    t0       = (state_q == RUN && pend_q) ? pend0_q : tgt0_q;
    t1       = (state_q == RUN && pend_q) ? pend1_q : tgt1_q;
    if (!enable_i || state_q == IDLE) begin
      state_d = enable_i ? RUN : IDLE;
      act0_d  = neutral_0_i;
      act1_d  = neutral_1_i;
      tgt0_d  = neutral_0_i;
      tgt1_d  = neutral_1_i;
      pend_d  = 1'b0;
      wcnt_d  = '0;
    end else begin
      if (frame_i) begin
        tgt0_d = t0;
        tgt1_d = t1;
        act0_d = slew(act0_q, t0, max_step_i);
        act1_d = slew(act1_q, t1, max_step_i);
        if (state_q == RUN) begin
          pend_d = 1'b0;
          wcnt_d = wcnt_inc;
          expire = wdog_frames_i != '0 && wcnt_inc == wdog_frames_i && !accept;
        end
      end
      if (accept) begin
        pend_d  = 1'b1;
        pend0_d = cmd_active_0_i;
        pend1_d = cmd_active_1_i;
        wcnt_d  = '0;
        state_d = RUN;
      end
      if (expire) begin
        state_d = FAILSAFE;
        tgt0_d  = neutral_0_i;
        tgt1_d  = neutral_1_i;
        pend_d  = 1'b0;
        trip_d  = trip_q == 16'hFFFF ? trip_q : trip_q + 16'd1;
      end
    end
    ready_d = state_d != IDLE && !pend_d;
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      pend0_q <= '0;
      pend1_q <= '0;
      tgt0_q  <= '0;
      tgt1_q  <= '0;
      act0_q  <= '0;
      act1_q  <= '0;
      wcnt_q  <= '0;
      trip_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      tgt0_q  <= tgt0_d;
      tgt1_q  <= tgt1_d;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
      wcnt_q  <= wcnt_d;
      trip_q  <= trip_d;
    end
  end

  assign active_0_o      = act0_q;
  assign active_1_o      = act1_q;
  assign state_o         = state_q;
  assign failsafe_o      = state_q[1];
  assign cmd_ready_o     = ready_q;
  assign wdog_trip_cnt_o = trip_q;
endmodule

// File: tb/tb_pwm_cmd_sched.sv
// tb_pwm_cmd_sched: directed vector table plus hand sequences for watchdog, reset and width corners
module tb_pwm_cmd_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, fr = 1'b0, vl = 1'b0, rdy, fs;
  logic [23:0] c0 = '0, c1 = '0, n0 = 24'd1500, n1 = 24'd1500, step = '0, a0, a1;
  logic [7:0] wdog = '0;
  logic [1:0] st;
  logic [15:0] trip;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit en, fr, vl;
    int c0, c1, step, e0, e1, est, erdy;
  } vec_t;
  vec_t tv[19];

  pwm_cmd_sched dut (
    .axi_clk(clk), .axi_rstn(rst_n), .enable_i(en), .frame_i(fr), .cmd_valid_i(vl),
    .cmd_ready_o(rdy), .cmd_active_0_i(c0), .cmd_active_1_i(c1), .neutral_0_i(n0),
    .neutral_1_i(n1), .max_step_i(step), .wdog_frames_i(wdog), .active_0_o(a0),
    .active_1_o(a1), .state_o(st), .failsafe_o(fs), .wdog_trip_cnt_o(trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e0, e1, est, erdy);
    chk({tag, " act0"}, int'(a0), e0);
    chk({tag, " act1"}, int'(a1), e1);
    chk({tag, " state"}, int'(st), est);
    chk({tag, " ready"}, int'(rdy), erdy);
  endtask

  task automatic cyc(input bit e, f, v, input int x0 = 0, x1 = 0);
    en = e;
    fr = f;
    vl = v;
    c0 = 24'(x0);
    c1 = 24'(x1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1, 0, 0, 0, 0, 0, 1500, 1500, 1, 1};
    tv[1]  = '{1, 0, 1, 2000, 1000, 0, 1500, 1500, 1, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 0, 1500, 1500, 1, 0};
    tv[3]  = '{1, 1, 0, 0, 0, 0, 2000, 1000, 1, 1};
    tv[4]  = '{1, 0, 0, 0, 0, 0, 2000, 1000, 1, 1};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 1500, 1500, 0, 0};
    tv[6]  = '{1, 0, 0, 0, 0, 100, 1500, 1500, 1, 1};
    tv[7]  = '{1, 0, 1, 1750, 1250, 100, 1500, 1500, 1, 0};
    tv[8]  = '{1, 1, 0, 0, 0, 100, 1600, 1400, 1, 1};
    tv[9]  = '{1, 0, 0, 0, 0, 100, 1600, 1400, 1, 1};
    tv[10] = '{1, 1, 0, 0, 0, 100, 1700, 1300, 1, 1};
    tv[11] = '{1, 1, 0, 0, 0, 100, 1750, 1250, 1, 1};
    tv[12] = '{1, 1, 0, 0, 0, 100, 1750, 1250, 1, 1};
    tv[13] = '{1, 1, 1, 1000, 2000, 0, 1750, 1250, 1, 0};
    tv[14] = '{1, 0, 0, 0, 0, 0, 1750, 1250, 1, 0};
    tv[15] = '{1, 1, 0, 0, 0, 0, 1000, 2000, 1, 1};
    tv[16] = '{1, 0, 1, 2000, 1000, 100, 1000, 2000, 1, 0};
    tv[17] = '{1, 1, 0, 0, 0, 100, 1100, 1900, 1, 1};
    tv[18] = '{0, 0, 0, 0, 0, 100, 1500, 1500, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset failsafe", int'(fs), 0);
    chk("reset trip", int'(trip), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk_out("idle load", 1500, 1500, 0, 0);

    for (int i = 0; i < 19; i++) begin
      step = 24'(tv[i].step);
      cyc(tv[i].en, tv[i].fr, tv[i].vl, tv[i].c0, tv[i].c1);
      chk_out($sformatf("vec%0d", i), tv[i].e0, tv[i].e1, tv[i].est, tv[i].erdy);
    end

    step = 24'd100;
    wdog = 8'd3;
    cyc(1, 0, 0);
    cyc(1, 0, 1, 1700, 1300);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk_out("wd frame2", 1700, 1300, 1, 1);
    cyc(1, 1, 0);
    chk_out("wd trip", 1700, 1300, 2, 1);
    chk("wd trip failsafe", int'(fs), 1);
    chk("wd trip cnt", int'(trip), 1);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk_out("fs neutral", 1500, 1500, 2, 1);
    cyc(1, 0, 1, 1800, 1200);
    chk_out("fs accept", 1500, 1500, 1, 0);
    chk("fs accept failsafe", int'(fs), 0);
    cyc(1, 1, 0);
    chk_out("fs cmd apply", 1600, 1400, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 1, 1900, 1100);
    chk_out("collide accept", 1800, 1200, 1, 0);
    chk("collide no trip", int'(trip), 1);
    cyc(1, 1, 0);
    chk_out("collide apply", 1900, 1100, 1, 1);
    cyc(1, 1, 0);
    chk("wd reset cnt2", int'(st), 1);
    cyc(1, 1, 0);
    chk_out("wd trip2", 1900, 1100, 2, 1);
    chk("wd trip2 cnt", int'(trip), 2);
    cyc(1, 1, 0);
    chk_out("fs slew", 1800, 1200, 2, 1);

    rst_n = 1'b0;
    #2;
    chk_out("async reset", 0, 0, 0, 0);
    chk("async reset failsafe", int'(fs), 0);
    chk("async reset trip", int'(trip), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    force dut.trip_q = 16'hFFFE;
    #1;
    release dut.trip_q;
    step = '0;
    wdog = 8'd1;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("sat trip reach", int'(trip), 16'hFFFF);
    chk("sat state", int'(st), 2);
    cyc(1, 0, 1, 1600, 1400);
    cyc(1, 1, 0);
    chk("sat trip hold", int'(trip), 16'hFFFF);
    chk_out("sat retrip", 1600, 1400, 2, 1);

    n0 = '0;
    n1 = '0;
    wdog = '0;
    step = 24'h800000;
    cyc(0, 0, 0);
    chk_out("wide idle", 0, 0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1, 24'hFFFFFF, 24'hFFFFFF);
    cyc(1, 1, 0);
    chk_out("wide up1", 24'h800000, 24'h800000, 1, 1);
    cyc(1, 1, 0);
    chk_out("wide up2", 24'hFFFFFF, 24'hFFFFFF, 1, 1);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0);
    chk_out("wide dn1", 24'h7FFFFF, 24'h7FFFFF, 1, 1);
    cyc(1, 1, 0);
    chk_out("wide dn2", 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
